// File: rtl/br_scan_if.sv
// rtl/br_scan_if.sv - control, bank read port and word stream bundle for br_scan
interface br_scan_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, first, last, abort, rd_data, out_ready,
        output rd_addr, out_valid, out_addr, out_data, busy, done
    );

    modport slave (
        output start, first, last, abort, rd_data, out_ready,
        input  rd_addr, out_valid, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/br_scan.sv
// rtl/br_scan.sv - sequential register-bank read-out engine with wrapping address range
module br_scan #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    br_scan_if.master   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_FIN
    } state_t;

    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
    logic [ADDR_W-1:0] out_addr_q, out_addr_n;
    logic [DATA_W-1:0] out_data_q, out_data_n;
    logic [ADDR_W:0]   remaining, remaining_n;
    logic [ADDR_W-1:0] span;

    // Modulo subtraction makes last < first wrap through the top of the bank.
    assign span = bus.last - bus.first;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q  <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            remaining  <= '0;
        end else begin
            rd_addr_q  <= rd_addr_n;
            out_addr_q <= out_addr_n;
            out_data_q <= out_data_n;
            remaining  <= remaining_n;
        end
    end

    always_comb begin
        state_n     = state;
        rd_addr_n   = rd_addr_q;
        out_addr_n  = out_addr_q;
        out_data_n  = out_data_q;
        remaining_n = remaining;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n     = S_LOAD;
                    rd_addr_n   = bus.first;
                    remaining_n = {1'b0, span} + REM_ONE;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    state_n = S_IDLE;
                end else begin
                    // Captured at the same edge as any bank write, so the pre-write word is kept.
                    state_n    = S_SEND;
                    out_addr_n = rd_addr_q;
                    out_data_n = bus.rd_data;
                end
            end
            S_SEND: begin
                if (bus.abort) begin
                    state_n = S_IDLE;
                end else if (bus.out_ready) begin
                    if (remaining == REM_ONE) begin
                        state_n = S_FIN;
                    end else begin
                        state_n     = S_LOAD;
                        rd_addr_n   = rd_addr_q + ADDR_ONE;
                        remaining_n = remaining - REM_ONE;
                    end
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state == S_SEND);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_FIN);
endmodule

// File: tb/tb_br_scan.sv
// tb/tb_br_scan.sv - directed and randomized scans of br_scan against a word-list reference model
module tb_br_scan;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    br_scan_if #(.ADDR_W(5), .DATA_W(32)) bi ();
    logic [31:0] bank [32];
    assign bi.rd_data = bank[bi.rd_addr];

    br_scan #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bi)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_rd_addr"}, 32'(bi.rd_addr), 0);
        chk({pfx, "_out_addr"}, 32'(bi.out_addr), 0);
        chk({pfx, "_out_data"}, bi.out_data, 0);
        chk({pfx, "_out_valid"}, 32'(bi.out_valid), 0);
        chk({pfx, "_busy"}, 32'(bi.busy), 0);
        chk({pfx, "_done"}, 32'(bi.done), 0);
    endtask

    // mode 0: ready held high, 1: random ready plus start noise, 2: second word stalled 5 cycles.
    // wr_cyc > 0 writes wr_val to address f at the edge ending that scan cycle.
    task automatic run_scan(input int f, input int l, input int mode, input int wr_cyc,
                            input logic [31:0] wr_val);
        logic [4:0]  qa[$];
        logic [31:0] qd[$];
        logic [4:0]  pa;
        logic [31:0] pd;
        int n, idx, next_valid, done_at, hold;
        bit ended, prev_stall, wr_now, exp_v;
        n = ((l - f) & 31) + 1;
        for (int i = 0; i < n; i++) begin
            qa.push_back(5'((f + i) % 32));
            qd.push_back(bank[(f + i) % 32]);
        end
        bi.start     = 1'b1;
        bi.first     = 5'(f);
        bi.last      = 5'(l);
        bi.out_ready = (mode == 0);
        idx = 0; next_valid = 2; done_at = -1; hold = 0;
        ended = 0; prev_stall = 0; wr_now = 0; pa = '0; pd = '0;
        for (int cyc = 1; cyc <= 600 && !ended; cyc++) begin
            @(posedge clk);
            if (wr_now) bank[f % 32] <= wr_val;
            @(negedge clk);
            wr_now = (cyc == wr_cyc);
            if (done_at > 0 && cyc == done_at + 1) begin
                chk("busy_after_fin", 32'(bi.busy), 0);
                chk("done_after_fin", 32'(bi.done), 0);
                chk("valid_after_fin", 32'(bi.out_valid), 0);
                ended = 1;
            end else begin
                exp_v = (done_at < 0) && (cyc >= next_valid);
                chk("busy", 32'(bi.busy), 1);
                chk("done", 32'(bi.done), 32'(cyc == done_at));
                chk("out_valid", 32'(bi.out_valid), 32'(exp_v));
                if (cyc == 1) chk("rd_addr_first", 32'(bi.rd_addr), 32'(f));
                if (exp_v) begin
                    chk("out_addr", 32'(bi.out_addr), 32'(qa[idx]));
                    chk("out_data", bi.out_data, qd[idx]);
                    if (prev_stall) begin
                        chk("stall_addr", 32'(bi.out_addr), 32'(pa));
                        chk("stall_data", bi.out_data, pd);
                    end
                end
                if (mode == 0) begin
                    bi.out_ready = 1'b1;
                end else if (mode == 1) begin
                    bi.out_ready = 1'($urandom_range(0, 1));
                end else if (idx == 1 && exp_v && hold < 5) begin
                    bi.out_ready = 1'b0;
                    hold++;
                end else begin
                    bi.out_ready = 1'b1;
                end
                prev_stall = exp_v && !bi.out_ready;
                pa = bi.out_addr;
                pd = bi.out_data;
                if (exp_v && bi.out_ready) begin
                    idx++;
                    if (idx == n) done_at = cyc + 1;
                    else next_valid = cyc + 2;
                end
                if (mode == 1 && done_at < 0) begin
                    bi.start = 1'($urandom_range(0, 1));
                    bi.first = 5'($urandom_range(0, 31));
                    bi.last  = 5'($urandom_range(0, 31));
                end else begin
                    bi.start = 1'b0;
                end
            end
        end
        bi.start     = 1'b0;
        bi.out_ready = 1'b0;
        chk("scan_ended", 32'(ended), 1);
        chk("handshakes", 32'(idx), 32'(n));
    endtask

    initial begin
        rst_n        = 1'b0;
        bi.start     = 1'b1;
        bi.first     = 5'd7;
        bi.last      = 5'd9;
        bi.abort     = 1'b0;
        bi.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] <= 32'(i) * 32'h11111111;
        tick();
        tick();
        chk_reset_vals("rst");
        rst_n    = 1'b1;
        bi.start = 1'b0;
        tick();
        chk("idle_busy", 32'(bi.busy), 0);
        chk("idle_valid", 32'(bi.out_valid), 0);

        run_scan(3, 5, 0, 0, 32'h0);
        run_scan(30, 1, 1, 0, 32'h0);
        run_scan(7, 6, 0, 0, 32'h0);
        run_scan(0, 2, 2, 0, 32'h0);

        run_scan(4, 4, 0, 1, 32'hDEADBEEF);
        run_scan(4, 4, 1, 2, 32'hCAFEF00D);
        run_scan(4, 4, 0, 0, 32'h0);

        bi.start = 1'b1; bi.first = 5'd0; bi.last = 5'd9; bi.out_ready = 1'b1;
        tick();
        bi.start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_valid", 32'(bi.out_valid), 1);
        chk("abort_pre_addr", 32'(bi.out_addr), 1);
        bi.abort = 1'b1;
        tick();
        bi.abort = 1'b0;
        chk("abort_valid", 32'(bi.out_valid), 0);
        chk("abort_busy", 32'(bi.busy), 0);
        chk("abort_done", 32'(bi.done), 0);
        tick();
        chk("abort_done_late", 32'(bi.done), 0);

        bi.start = 1'b1; bi.first = 5'd5; bi.last = 5'd9;
        tick();
        chk("rst_load_busy", 32'(bi.busy), 1);
        bi.start = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        bi.out_ready = 1'b0;
        tick();
        chk("postrst_busy", 32'(bi.busy), 0);
        run_scan(2, 2, 0, 0, 32'h0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 32; i++) bank[i] <= $urandom;
            tick();
            run_scan($urandom_range(0, 31), $urandom_range(0, 31), 1, 0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
